// File: rtl/demux_pkg.sv
// Shared types for the demux feeder: select width, channel count,
// feeder FSM states and the buffered {dest, data} word.
package demux_pkg;

    localparam int SEL_W  = 3;
    localparam int NUM_CH = 8;
    localparam int WORD_W = SEL_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } feed_state_t;

    typedef struct packed {
        logic [SEL_W-1:0] dest;
        logic             data;
    } word_t;

endpackage

// File: rtl/demux_feed_fifo.sv
// Small synchronous FIFO of feeder words with occupancy count.
// The head word is presented combinationally from storage.
module demux_feed_fifo
    import demux_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  word_t                        din,
    output word_t                        dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    word_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux_feed_ctrl.sv
// Feeds buffered {dest, data} words to the 1:8 demux as registered
// select/data pairs held for HOLD cycles, each followed by GAP idle cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | nothing in flight; launch as soon as the FIFO has a word
// ST_HOLD | dmx_s/dmx_i driven with the current word, cnt counts down
// ST_GAP  | dmx_i forced 0, dmx_s held; launch or idle when cnt hits 0
module demux_feed_ctrl
    import demux_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 3,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_dest,
    input  logic             in_bit,
    output logic             dmx_i,
    output logic [SEL_W-1:0] dmx_s,
    output logic             dlv_done,
    output logic             busy
);

    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam int MAX_LD = (HOLD > GAP) ? HOLD : GAP;
    localparam int CNT_W  = $clog2(MAX_LD + 1);
    localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(DEPTH);

    feed_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              dmx_i_nxt;
    logic [SEL_W-1:0]  dmx_s_nxt;
    logic              launch;
    logic              push;
    word_t             in_word;
    word_t             head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;

    assign in_word.dest = in_dest;
    assign in_word.data = in_bit;
    assign in_ready     = (fifo_count != FULL_CNT);
    assign push         = in_valid && !fifo_full;

    demux_feed_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (launch),
        .din   (in_word),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dmx_i <= 1'b0;
            dmx_s <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dmx_i <= dmx_i_nxt;
            dmx_s <= dmx_s_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dmx_i_nxt = dmx_i;
        dmx_s_nxt = dmx_s;
        launch    = 1'b0;
        case (state)
            ST_IDLE: begin
                launch = !fifo_empty;
            end
            ST_HOLD: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    dmx_i_nxt = 1'b0;
                    cnt_nxt   = GAP_LD;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (!fifo_empty) begin
                    launch = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Launch straight out of GAP avoids a dead cycle between words.
        if (launch) begin
            dmx_s_nxt = head.dest;
            dmx_i_nxt = head.data;
            cnt_nxt   = HOLD_LD;
            state_nxt = ST_HOLD;
        end
    end

    assign dlv_done = (state == ST_HOLD) && (cnt == '0);
    assign busy     = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_demux_feed_ctrl.sv
// Self-checking bench for demux_feed_ctrl driving a behavioural 1:8 demux;
// a scoreboard queue holds accepted words until their delivery pulse.
module tb_demux_feed_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_dest;
    logic       in_bit;
    logic       dmx_i;
    logic [2:0] dmx_s;
    logic       dlv_done;
    logic       busy;
    logic [7:0] dmx_d;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int dlv_count = 0;
    int dest6_count = 0;
    logic [3:0] sb [$];

    demux_feed_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_dest  (in_dest),
        .in_bit   (in_bit),
        .dmx_i    (dmx_i),
        .dmx_s    (dmx_s),
        .dlv_done (dlv_done),
        .busy     (busy)
    );

    // existing 1:8 demux: I routed to output S, all others 0
    always_comb begin
        dmx_d = 8'h00;
        if (dmx_i) dmx_d = 8'h01 << dmx_s;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: each delivery pulse pops the oldest accepted word
    always @(negedge clk) begin
        if (rst_n && dlv_done) begin
            logic [3:0] exp_w;
            logic [7:0] exp_d;
            dlv_count = dlv_count + 1;
            if (dmx_s == 3'd6) dest6_count = dest6_count + 1;
            n_cmp = n_cmp + 1;
            if (sb.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL unexpected_delivery dest=%0d bit=%0d with empty scoreboard", dmx_s, dmx_i);
            end else begin
                exp_w = sb.pop_front();
                exp_d = exp_w[0] ? (8'h01 << exp_w[3:1]) : 8'h00;
                if (dmx_s !== exp_w[3:1]) begin
                    n_bad = n_bad + 1;
                    $display("FAIL delivery_sel got=%0d exp=%0d", dmx_s, exp_w[3:1]);
                end
                n_cmp = n_cmp + 1;
                if (dmx_d !== exp_d) begin
                    n_bad = n_bad + 1;
                    $display("FAIL delivery_demux got=%b exp=%b", dmx_d, exp_d);
                end
            end
        end
    end

    task automatic send(input logic [2:0] d, input logic b, output int acc);
        acc = -1;
        in_valid = 1'b1;
        in_dest  = d;
        in_bit   = b;
        for (int t = 0; t < 100; t++) begin
            if (in_ready) begin
                sb.push_back({d, b});
                @(negedge clk);
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (acc < 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL send_timeout dest=%0d not accepted within 100 cycles", d);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || sb.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp = n_cmp + 1;
        if (busy !== 1'b0 || sb.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL idle_timeout busy=%b pending=%0d exp busy=0 pending=0", busy, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_dest  = 3'd0;
        in_bit   = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp = n_cmp + 4;
        if (dmx_i !== 1'b0) begin n_bad++; $display("FAIL reset_dmx_i got=%b exp=0", dmx_i); end
        if (dmx_s !== 3'd0) begin n_bad++; $display("FAIL reset_dmx_s got=%0d exp=0", dmx_s); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (dlv_done !== 1'b0) begin n_bad++; $display("FAIL reset_dlv_done got=%b exp=0", dlv_done); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp = n_cmp + 2;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        int acc;
        send(3'd5, 1'b1, acc);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_cmp = n_cmp + 3;
            if (dmx_i !== 1'(c <= 3)) begin n_bad++; $display("FAIL single_dmx_i c=%0d got=%b exp=%b", c, dmx_i, c <= 3); end
            if (dlv_done !== 1'(c == 3)) begin n_bad++; $display("FAIL single_dlv_done c=%0d got=%b exp=%b", c, dlv_done, c == 3); end
            if (busy !== 1'(c < 5)) begin n_bad++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, c < 5); end
            if (c <= 3) begin
                n_cmp = n_cmp + 2;
                if (dmx_s !== 3'd5) begin n_bad++; $display("FAIL single_dmx_s c=%0d got=%0d exp=5", c, dmx_s); end
                if (dmx_d !== 8'b00100000) begin n_bad++; $display("FAIL single_demux c=%0d got=%b exp=00100000", c, dmx_d); end
            end
        end
        wait_idle();
    endtask

    task automatic test_stream();
        int acc0;
        int base;
        int exp_off [8];
        exp_off = '{0, 1, 2, 3, 4, 6, 10, 14};
        base = dlv_count;
        send(3'd0, 1'b1, acc0);
        fork
            begin
                int acc;
                for (int i = 1; i < 8; i++) begin
                    send(3'(i), 1'b1, acc);
                    n_cmp = n_cmp + 1;
                    if (acc - acc0 != exp_off[i]) begin
                        n_bad++;
                        $display("FAIL stream_accept word=%0d got_cycle=%0d exp_cycle=%0d", i, acc - acc0, exp_off[i]);
                    end
                end
            end
            begin
                for (int c = 1; c <= 34; c++) begin
                    int k;
                    int ph;
                    logic [7:0] exp_d;
                    logic exp_done;
                    @(negedge clk);
                    k  = (c - 1) / 4;
                    ph = (c - 1) % 4;
                    exp_d    = (c <= 32 && ph < 3) ? (8'h01 << k) : 8'h00;
                    exp_done = (c <= 32 && ph == 2);
                    n_cmp = n_cmp + 2;
                    if (dmx_d !== exp_d) begin n_bad++; $display("FAIL stream_demux c=%0d got=%b exp=%b", c, dmx_d, exp_d); end
                    if (dlv_done !== exp_done) begin n_bad++; $display("FAIL stream_dlv_done c=%0d got=%b exp=%b", c, dlv_done, exp_done); end
                    if (c == 4) begin
                        n_cmp = n_cmp + 1;
                        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stream_full_ready got=%b exp=0", in_ready); end
                    end
                end
            end
        join
        wait_idle();
        n_cmp = n_cmp + 1;
        if (dlv_count - base != 8) begin
            n_bad++;
            $display("FAIL stream_pulse_count got=%0d exp=8", dlv_count - base);
        end
    endtask

    task automatic test_zero_bit();
        int acc;
        send(3'd3, 1'b0, acc);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_cmp = n_cmp + 4;
            if (dmx_s !== 3'd3) begin n_bad++; $display("FAIL zero_dmx_s c=%0d got=%0d exp=3", c, dmx_s); end
            if (dmx_i !== 1'b0) begin n_bad++; $display("FAIL zero_dmx_i c=%0d got=%b exp=0", c, dmx_i); end
            if (dmx_d !== 8'h00) begin n_bad++; $display("FAIL zero_demux c=%0d got=%b exp=00000000", c, dmx_d); end
            if (dlv_done !== 1'(c == 3)) begin n_bad++; $display("FAIL zero_dlv_done c=%0d got=%b exp=%b", c, dlv_done, c == 3); end
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int acc0;
        int acc;
        int base6;
        logic [2:0] fill [4];
        fill = '{3'd2, 3'd3, 3'd4, 3'd7};
        base6 = dest6_count;
        send(3'd1, 1'b1, acc0);
        foreach (fill[i]) send(fill[i], 1'b1, acc);
        n_cmp = n_cmp + 1;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        send(3'd6, 1'b1, acc);
        n_cmp = n_cmp + 1;
        if (acc - acc0 != 6) begin n_bad++; $display("FAIL bp_accept_cycle got=%0d exp=6", acc - acc0); end
        wait_idle();
        n_cmp = n_cmp + 1;
        if (dest6_count - base6 != 1) begin n_bad++; $display("FAIL bp_dest6_deliveries got=%0d exp=1", dest6_count - base6); end
    endtask

    task automatic test_reset_mid_hold();
        int acc;
        int base;
        send(3'd1, 1'b1, acc);
        send(3'd2, 1'b1, acc);
        send(3'd4, 1'b1, acc);
        n_cmp = n_cmp + 2;
        if (dmx_s !== 3'd1 || dmx_i !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_hold got=%0d/%b exp=1/1", dmx_s, dmx_i); end
        if (dlv_done !== 1'b0) begin n_bad++; $display("FAIL rmid_pre_done got=%b exp=0", dlv_done); end
        rst_n = 1'b0;
        #1;
        sb.delete();
        base = dlv_count;
        n_cmp = n_cmp + 3;
        if (dmx_i !== 1'b0) begin n_bad++; $display("FAIL rmid_dmx_i got=%b exp=0", dmx_i); end
        if (dmx_s !== 3'd0) begin n_bad++; $display("FAIL rmid_dmx_s got=%0d exp=0", dmx_s); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp = n_cmp + 3;
        if (dlv_count != base) begin n_bad++; $display("FAIL rmid_deliveries got=%0d exp=0", dlv_count - base); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_after got=%b exp=0", busy); end
        if (dmx_i !== 1'b0) begin n_bad++; $display("FAIL rmid_dmx_i_after got=%b exp=0", dmx_i); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_zero_bit();
        test_backpressure();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/demux_feed_ctrl.md
# demux_feed_ctrl

Upstream feeder for the 1:8 demultiplexer. It accepts {destination, data bit} words over a valid/ready handshake and buffers them in a small FIFO. Each word is presented to the demux as a registered select/data pair for a fixed hold window, followed by an idle gap, so the combinational demux sees stable, glitch-free inputs and only one output channel is driven at a time.

## Interface
- DEPTH, default 4: FIFO entries; power of 2, ≥2.
- HOLD, default 3: cycles dmx_i carries the word's bit; ≥1.
- GAP, default 1: cycles dmx_i forced 0 after each hold window; ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_dest  in  3  destination channel 0..7.
- in_bit  in  1  data bit for that channel.
- dmx_i  out  1  registered data to demux I.
- dmx_s  out  3  registered select to demux S.
- dlv_done  out  1  high in the last HOLD cycle of each delivery.
- busy  out  1  high when the state is not IDLE or the FIFO is non-empty.

## Operation
- Push: a word is written when in_valid && in_ready at the rising edge. in_ready is low when count == DEPTH, and the word stays upstream until accepted. No drops.
- FIFO: first-in first-out with a count of width clog2(DEPTH+1). Pointers wrap modulo DEPTH.
- FSM states: IDLE, HOLD, GAP. A down-counter cnt is shared by HOLD and GAP.
- "Launch" means pop the head, set dmx_s = head.dest, set dmx_i = head.bit, set cnt = HOLD-1, and enter HOLD.
- IDLE: launch if the FIFO is non-empty, otherwise stay.
- HOLD: if cnt != 0, decrement. If cnt == 0, set dmx_i = 0, set cnt = GAP-1, and enter GAP.
- GAP: if cnt != 0, decrement. If cnt == 0, launch if the FIFO is non-empty, otherwise enter IDLE.
- dmx_s holds its last value through GAP and IDLE. Only dmx_i is zeroed.
- A word with bit = 0 is still a full delivery: dmx_s moves, dmx_i stays 0, and dlv_done pulses.
- Push and pop in the same cycle leave count unchanged.
- A push on a full FIFO cannot occur because in_ready = 0. A slot freed by a pop is visible as in_ready = 1 the next cycle.
- Reset mid-operation: all queued and in-flight words are discarded. The hold window is truncated immediately.

## Timing
- Reset values: dmx_i = 0, dmx_s = 0, dlv_done = 0, busy = 0, state = IDLE, count = 0. in_ready = 1 once rst_n is high.
- Latency: a word accepted at edge k into an empty FIFO while IDLE launches at edge k+1. dmx_i/dmx_s are valid from k+1 through k+HOLD.
- dlv_done is high for exactly one cycle, the final HOLD cycle.
- Throughput: one word per HOLD+GAP cycles, which is 4 at the defaults. There is no dead cycle between GAP and the next launch.
- busy falls the cycle after the final GAP when the FIFO is empty.
- All outputs are registered or decoded from registers. No input-to-output combinational path except in_ready, which is derived from count.

## Structure
- Shared package demux_pkg holds:
  - SEL_W = 3 and NUM_CH = 8.
  - A state enum {IDLE, HOLD, GAP}.
  - A word typedef {dest[SEL_W-1:0], bit}.
- Sub-module demux_feed_fifo: a synchronous DEPTH × 4-bit FIFO with push, pop, full, empty and count, and asynchronous active-low reset. The FSM and counters sit in the top level.
- In the test bench, the top level drives the existing 1:8 demux directly: dmx_i → I, dmx_s → S.

## Test plan
- Reset test: hold rst_n low. Required: dmx_i = 0, dmx_s = 0, busy = 0, dlv_done = 0. After release, in_ready = 1.
- Single delivery: push dest = 5, bit = 1 at cycle 0. Required:
  - dmx_s = 5 and dmx_i = 1 in cycles 1–3, so demux D = 8'b00100000.
  - dlv_done high in cycle 3.
  - dmx_i = 0 in cycle 4, and busy = 0 from cycle 5.
- Streaming: hold in_valid with dest = 0..7, bit = 1. Required:
  - in_ready drops once 4 entries are buffered.
  - Launches occur every 4 cycles in order, so D walks 00000001 → 10000000 with D = 0 in each GAP cycle.
  - Exactly 8 dlv_done pulses.
- Zero bit: push dest = 3, bit = 0. Required: dmx_s = 3, dmx_i stays 0, D = 0, and dlv_done still pulses in cycle 3.
- Backpressure: fill the FIFO, then hold in_valid with dest = 6. Required: the word is not accepted while in_ready = 0, is accepted the cycle after the next pop, and is delivered exactly once.
- Reset mid-HOLD: assert rst_n during the second HOLD cycle with 2 words queued. Required: dmx_i and dmx_s go to 0 immediately, busy = 0, and no further deliveries occur after release.
